// File: rtl/timed_cmd_queue.sv
// timed_cmd_queue
//   Holds up to DEPTH timestamped commands. A sequential scan (one slot per
//   cycle) selects the earliest valid command. That command is presented on
//   the out_* handshake once its time is within LEAD cycles of time_now.
//
// Ports
//   CLK, rst          single clock; asynchronous active-high reset
//   time_now          current system time
//   time_reload       one-cycle pulse: system time was re-set, rescan needed
//   flush             synchronous clear of every slot (highest priority)
//   wr_valid/wr_ready/wr_time/wr_payload      command write handshake
//   out_valid/out_ready/out_time/out_payload  command issue handshake
//   count, full       occupancy
//   drop_cnt          stale commands discarded (saturating)
//
// Build option
//   TCQ_STALE_DROP_EN  when defined, the scan discards slots whose time is
//                      already in the past and counts them in drop_cnt;
//                      otherwise stale slots are issued normally and
//                      drop_cnt reads 0.
module timed_cmd_queue #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PAYLOAD_W = 274,
  parameter int unsigned TIME_W    = 64,
  parameter int unsigned LEAD      = 384
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic [TIME_W-1:0]            time_now,
  input  logic                         time_reload,
  input  logic                         flush,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [TIME_W-1:0]            wr_time,
  input  logic [PAYLOAD_W-1:0]         wr_payload,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [TIME_W-1:0]            out_time,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic [15:0]                  drop_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [TIME_W:0] LEAD_X = (TIME_W + 1)'(LEAD);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD, ISSUE} state_t;

  state_t state, state_d;

  logic [DEPTH-1:0]     slot_valid;
  logic [TIME_W-1:0]    slot_time    [DEPTH];
  logic [PAYLOAD_W-1:0] slot_payload [DEPTH];

  logic                 init_done;
  logic                 reload_pend;
  logic [IDX_W-1:0]     scan_idx;
  logic                 cand_found;
  logic [IDX_W-1:0]     cand_idx;
  logic [TIME_W-1:0]    cand_time;

  logic [IDX_W-1:0]     free_idx;
  logic                 wr_acc;
  logic                 hs;
  logic                 scan_restart;
  logic                 scan_step;
  logic                 scan_last;
  logic                 cur_valid;
  logic [TIME_W-1:0]    cur_time;
  logic                 cur_stale;
  logic                 take;
  logic [TIME_W:0]      lead_sum;
  logic [TIME_W-1:0]    lead_limit;
  logic                 due;

  assign full      = (count == CNT_W'(DEPTH));
  assign out_valid = (state == ISSUE);
  // init_done keeps wr_ready low until the first edge after reset release.
  assign wr_ready  = init_done && !full && !flush && (state == IDLE || state == HOLD);
  assign wr_acc    = wr_valid && wr_ready;
  assign hs        = (state == ISSUE) && out_ready && !flush;

  // Lowest-index free slot.
  always_comb begin
    logic hit;
    hit      = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!slot_valid[i] && !hit) begin
        hit      = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Saturating issue horizon.
  assign lead_sum   = {1'b0, time_now} + LEAD_X;
  assign lead_limit = lead_sum[TIME_W] ? '1 : lead_sum[TIME_W-1:0];
  assign due        = (cand_time <= lead_limit);

  assign cur_valid = slot_valid[scan_idx];
  assign cur_time  = slot_time[scan_idx];
  assign scan_last = (scan_idx == IDX_W'(DEPTH - 1));

`ifdef TCQ_STALE_DROP_EN
  assign cur_stale = cur_valid && (cur_time < time_now);
`else
  assign cur_stale = 1'b0;
  assign drop_cnt  = '0;
`endif

  // Strict less-than while walking upward keeps the lower index on ties.
  assign take = cur_valid && !cur_stale && (!cand_found || (cur_time < cand_time));

  always_comb begin
    state_d      = state;
    scan_restart = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (wr_acc || time_reload || reload_pend) begin
            state_d      = SCAN;
            scan_restart = 1'b1;
          end
        end
        SCAN: begin
          if (time_reload) begin
            scan_restart = 1'b1;
          end else if (scan_last) begin
            state_d = (cand_found || take) ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (wr_acc || time_reload || reload_pend) begin
            state_d      = SCAN;
            scan_restart = 1'b1;
          end else if (due) begin
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (out_ready) begin
            state_d      = SCAN;
            scan_restart = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign scan_step = (state == SCAN) && !flush && !time_reload;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      init_done   <= 1'b0;
      slot_valid  <= '0;
      count       <= '0;
      reload_pend <= 1'b0;
      scan_idx    <= '0;
      cand_found  <= 1'b0;
      cand_idx    <= '0;
      cand_time   <= '0;
      out_time    <= '0;
      out_payload <= '0;
    end else begin
      state     <= state_d;
      init_done <= 1'b1;
      if (flush) begin
        slot_valid  <= '0;
        count       <= '0;
        reload_pend <= 1'b0;
        cand_found  <= 1'b0;
      end else begin
        // Write, issue and stale drop are mutually exclusive by state.
        if (wr_acc) begin
          slot_valid[free_idx] <= 1'b1;
          count                <= count + CNT_W'(1);
        end
        if (hs) begin
          slot_valid[cand_idx] <= 1'b0;
          count                <= count - CNT_W'(1);
        end

        // A reload during ISSUE waits for the handshake; the rescan that
        // follows the handshake services it.
        if (state == ISSUE && time_reload && !out_ready) begin
          reload_pend <= 1'b1;
        end else if (scan_restart) begin
          reload_pend <= 1'b0;
        end

        if (scan_restart) begin
          scan_idx   <= '0;
          cand_found <= 1'b0;
        end else if (scan_step) begin
          scan_idx <= scan_idx + IDX_W'(1);
          if (take) begin
            cand_found <= 1'b1;
            cand_idx   <= scan_idx;
            cand_time  <= cur_time;
          end
          if (cur_stale) begin
            slot_valid[scan_idx] <= 1'b0;
            count                <= count - CNT_W'(1);
          end
        end

        if (state == HOLD && state_d == ISSUE) begin
          out_time    <= cand_time;
          out_payload <= slot_payload[cand_idx];
        end
      end
    end
  end

`ifdef TCQ_STALE_DROP_EN
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (scan_step && cur_stale && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  // Slot data carries no reset; validity lives in slot_valid.
  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      slot_time[free_idx]    <= wr_time;
      slot_payload[free_idx] <= wr_payload;
    end
  end

endmodule

// File: tb/tb_timed_cmd_queue.sv
module tb_timed_cmd_queue;

  localparam int TW = 64;
  localparam int PW = 274;

  logic          CLK = 1'b0;
  logic          rst;
  logic [TW-1:0] time_now;
  logic          time_reload;
  logic          flush;
  logic          wr_valid;
  logic          wr_ready;
  logic [TW-1:0] wr_time;
  logic [PW-1:0] wr_payload;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_time;
  logic [PW-1:0] out_payload;
  logic [4:0]    count;
  logic          full;
  logic [15:0]   drop_cnt;

  int checks = 0;
  int errors = 0;

  timed_cmd_queue #(
    .DEPTH    (16),
    .PAYLOAD_W(PW),
    .TIME_W   (TW),
    .LEAD     (384)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .time_now   (time_now),
    .time_reload(time_reload),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_time    (wr_time),
    .wr_payload (wr_payload),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_time   (out_time),
    .out_payload(out_payload),
    .count      (count),
    .full       (full),
    .drop_cnt   (drop_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic logic [PW-1:0] pl(input logic [31:0] v);
    return {v, 210'(0), v};
  endfunction

  task automatic clean();
    @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
  endtask

  task automatic do_write(input logic [TW-1:0] t, input logic [PW-1:0] p, output bit ok);
    ok = 1'b0;
    @(negedge CLK);
    wr_valid   = 1'b1;
    wr_time    = t;
    wr_payload = p;
    for (int i = 0; i < 100; i++) begin
      if (wr_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (ok) begin
      @(posedge CLK);
      #1;
    end
    wr_valid = 1'b0;
  endtask

  task automatic do_issue(output logic [TW-1:0] t, output logic [PW-1:0] p, output bit ok);
    ok = 1'b0;
    t  = '0;
    p  = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      t = out_time;
      p = out_payload;
      out_ready = 1'b1;
      @(posedge CLK);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({count, full, wr_ready, out_valid, drop_cnt} !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs count=%0d full=%b wr_ready=%b out_valid=%b drop=%0d expected all 0",
               count, full, wr_ready, out_valid, drop_cnt);
    end
    checks++;
    if (out_time !== '0 || out_payload !== '0) begin
      errors++;
      $display("FAIL reset_out_data time=%h payload=%h expected 0", out_time, out_payload);
    end
    @(negedge CLK);
    rst = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge wr_ready=%b expected 0", wr_ready);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_edge wr_ready=%b expected 1", wr_ready);
    end
  endtask

  task automatic test_latency();
    bit ok;
    int lat;
    logic [TW-1:0] t;
    logic [PW-1:0] p;
    time_now = 900;
    do_write(1000, pl(1), ok);
    checks++;
    if (!ok || count !== 5'd1 || wr_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_accept ok=%b count=%0d wr_ready=%b out_valid=%b expected 1,1,0,0",
               ok, count, wr_ready, out_valid);
    end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 17) begin
      errors++;
      $display("FAIL lat_issue edges=%0d expected 17", lat);
    end
    do_issue(t, p, ok);
    checks++;
    if (!ok || t !== 64'd1000 || p !== pl(1) || count !== 5'd0) begin
      errors++;
      $display("FAIL lat_data ok=%b time=%0d count=%0d expected time 1000 count 0", ok, t, count);
    end
    repeat (20) @(posedge CLK);
  endtask

  task automatic test_order();
    bit ok, all_ok;
    logic [TW-1:0] t;
    logic [PW-1:0] p;
    time_now = 1000;
    all_ok = 1'b1;
    do_write(5000, pl(5), ok); all_ok &= ok;
    do_write(3000, pl(3), ok); all_ok &= ok;
    do_write(4000, pl(4), ok); all_ok &= ok;
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (!all_ok || out_valid !== 1'b0 || count !== 5'd3) begin
      errors++;
      $display("FAIL order_hold ok=%b out_valid=%b count=%0d expected 1,0,3", all_ok, out_valid, count);
    end
    time_now = 2615;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_early_3000 out_valid=%b expected 0", out_valid);
    end
    @(negedge CLK);
    time_now = 2616;
    @(posedge CLK);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_time !== 64'd3000 || out_payload !== pl(3)) begin
      errors++;
      $display("FAIL order_first out_valid=%b time=%0d expected 1 time 3000", out_valid, out_time);
    end
    do_issue(t, p, ok);
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    time_now = 3615;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL order_early_4000 out_valid=%b expected 0", out_valid);
    end
    @(negedge CLK);
    time_now = 3616;
    @(posedge CLK);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_time !== 64'd4000 || out_payload !== pl(4)) begin
      errors++;
      $display("FAIL order_second out_valid=%b time=%0d expected 1 time 4000", out_valid, out_time);
    end
    do_issue(t, p, ok);
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    time_now = 4616;
    @(posedge CLK);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_time !== 64'd5000 || out_payload !== pl(5)) begin
      errors++;
      $display("FAIL order_third out_valid=%b time=%0d expected 1 time 5000", out_valid, out_time);
    end
    do_issue(t, p, ok);
    checks++;
    if (!ok || count !== 5'd0) begin
      errors++;
      $display("FAIL order_drain ok=%b count=%0d expected 1,0", ok, count);
    end
  endtask

  task automatic test_tie();
    bit ok, all_ok;
    logic [TW-1:0] t;
    logic [PW-1:0] p;
    clean();
    time_now = 0;
    all_ok = 1'b1;
    do_write(9000, pl(10), ok); all_ok &= ok;
    do_write(9000, pl(11), ok); all_ok &= ok;
    do_write(2000, pl(12), ok); all_ok &= ok;
    do_write(9000, pl(13), ok); all_ok &= ok;
    do_write(9000, pl(14), ok); all_ok &= ok;
    do_write(2000, pl(15), ok); all_ok &= ok;
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    time_now = 1700;
    do_issue(t, p, ok);
    checks++;
    if (!all_ok || !ok || t !== 64'd2000 || p !== pl(12)) begin
      errors++;
      $display("FAIL tie_first ok=%b/%b time=%0d payload=%h expected slot 2 payload %h",
               all_ok, ok, t, p, pl(12));
    end
    do_issue(t, p, ok);
    checks++;
    if (!ok || t !== 64'd2000 || p !== pl(15) || count !== 5'd4) begin
      errors++;
      $display("FAIL tie_second ok=%b time=%0d count=%0d payload=%h expected slot 5 count 4",
               ok, t, count, p);
    end
    clean();
  endtask

  task automatic test_full();
    bit ok, all_ok, seen;
    logic [TW-1:0] t;
    logic [PW-1:0] p;
    time_now = 0;
    all_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      do_write(64'(10000 + i), pl(32'(100 + i)), ok);
      all_ok &= ok;
    end
    checks++;
    if (!all_ok || full !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL full_fill ok=%b full=%b count=%0d expected 1,1,16", all_ok, full, count);
    end
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    wr_valid   = 1'b1;
    wr_time    = 9700;
    wr_payload = pl(777);
    repeat (5) @(negedge CLK);
    checks++;
    if (wr_ready !== 1'b0 || count !== 5'd16) begin
      errors++;
      $display("FAIL full_stall wr_ready=%b count=%0d expected 0,16", wr_ready, count);
    end
    time_now = 9616;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    t = out_time;
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    checks++;
    if (!seen || t !== 64'd10000 || count !== 5'd15) begin
      errors++;
      $display("FAIL full_issue seen=%b time=%0d count=%0d expected 1,10000,15", seen, t, count);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (wr_ready) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge CLK);
    #1;
    wr_valid = 1'b0;
    checks++;
    if (!seen || count !== 5'd16 || full !== 1'b1) begin
      errors++;
      $display("FAIL full_refill seen=%b count=%0d full=%b expected 1,16,1", seen, count, full);
    end
    do_issue(t, p, ok);
    checks++;
    if (!ok || t !== 64'd9700 || p !== pl(777)) begin
      errors++;
      $display("FAIL full_held_data ok=%b time=%0d expected held write time 9700", ok, t);
    end
    clean();
  endtask

  task automatic test_saturate();
    bit ok;
    logic [TW-1:0] t;
    logic [PW-1:0] p;
    time_now = 64'hFFFF_FFFF_FFFF_FF00;
    do_write('1, pl(55), ok);
    do_issue(t, p, ok);
    checks++;
    if (!ok || t !== {TW{1'b1}} || p !== pl(55)) begin
      errors++;
      $display("FAIL sat_issue ok=%b time=%h expected all-ones issued", ok, t);
    end
    repeat (20) @(posedge CLK);
  endtask

  task automatic test_flush_reload();
    bit ok, seen, stable;
    clean();
    time_now = 5000;
    do_write(5100, pl(66), ok);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      if (out_valid !== 1'b1 || out_time !== 64'd5100 || out_payload !== pl(66)) stable = 1'b0;
    end
    checks++;
    if (!ok || !seen || !stable) begin
      errors++;
      $display("FAIL hold_stable ok=%b seen=%b stable=%b expected 1,1,1", ok, seen, stable);
    end
    @(negedge CLK);
    time_reload = 1'b1;
    @(posedge CLK);
    #1;
    time_reload = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_time !== 64'd5100) begin
      errors++;
      $display("FAIL reload_in_issue out_valid=%b time=%0d expected 1,5100", out_valid, out_time);
    end
    @(negedge CLK);
    time_reload = 1'b1;
    flush       = 1'b1;
    wr_valid    = 1'b1;
    wr_time     = 7000;
    wr_payload  = pl(67);
    @(posedge CLK);
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL flush_reload out_valid=%b count=%0d expected 0,0", out_valid, count);
    end
    time_reload = 1'b0;
    flush       = 1'b0;
    wr_valid    = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL flush_write_dropped out_valid=%b count=%0d expected 0,0", out_valid, count);
    end
  endtask

  task automatic test_stale();
    bit ok;
    logic [TW-1:0] t;
    logic [PW-1:0] p;
    clean();
    time_now = 0;
    do_write(100, pl(88), ok);
    time_now = 500;
    repeat (25) @(posedge CLK);
    #1;
`ifdef TCQ_STALE_DROP_EN
    checks++;
    if (!ok || out_valid !== 1'b0 || drop_cnt !== 16'd1 || count !== 5'd0) begin
      errors++;
      $display("FAIL stale_drop ok=%b out_valid=%b drop=%0d count=%0d expected 1,0,1,0",
               ok, out_valid, drop_cnt, count);
    end
`else
    checks++;
    if (!ok || out_valid !== 1'b1 || out_time !== 64'd100 || drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stale_issue ok=%b out_valid=%b time=%0d drop=%0d expected 1,1,100,0",
               ok, out_valid, out_time, drop_cnt);
    end
    do_issue(t, p, ok);
    checks++;
    if (!ok || p !== pl(88) || count !== 5'd0) begin
      errors++;
      $display("FAIL stale_drain ok=%b count=%0d expected 1,0", ok, count);
    end
`endif
  endtask

  task automatic test_reset_mid_scan();
    bit ok;
    clean();
    time_now = 0;
    do_write(7000, pl(9), ok);
    repeat (5) @(posedge CLK);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (!ok || {count, full, wr_ready, out_valid, drop_cnt} !== 24'h0 ||
        out_time !== '0 || out_payload !== '0) begin
      errors++;
      $display("FAIL reset_mid_scan ok=%b count=%0d full=%b wr_ready=%b out_valid=%b drop=%0d time=%h expected all 0",
               ok, count, full, wr_ready, out_valid, drop_cnt, out_time);
    end
    @(negedge CLK);
    rst = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready wr_ready=%b expected 1", wr_ready);
    end
    repeat (20) @(posedge CLK);
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL reset_discard out_valid=%b count=%0d expected 0,0", out_valid, count);
    end
  endtask

  initial begin
    rst         = 1'b1;
    time_now    = '0;
    time_reload = 1'b0;
    flush       = 1'b0;
    wr_valid    = 1'b0;
    wr_time     = '0;
    wr_payload  = '0;
    out_ready   = 1'b0;
    test_reset();
    test_latency();
    test_order();
    test_tie();
    test_full();
    test_saturate();
    test_flush_reload();
    test_stale();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timed_cmd_queue.md
TIMED_CMD_QUEUE -- requirements
Module: timed_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 16: number of command slots; power of 2, range 2..256.
REQ-002 Parameter PAYLOAD_W, default 274: command payload width in bits.
REQ-003 Parameter TIME_W, default 64: timestamp width in bits.
REQ-004 Parameter LEAD, default 384: issue lead time in CLK cycles (8 us at 48 MHz).
REQ-005 Port CLK  in  1: single clock, rising edge; all logic SHALL run in this one domain.
REQ-006 Port rst  in  1: asynchronous, active-high reset.
REQ-007 Port time_now  in  TIME_W: current system time.
REQ-008 Port time_reload  in  1: one-cycle pulse marking that system time was re-set.
REQ-009 Port flush  in  1: synchronous clear of all slots.
REQ-010 Ports wr_valid in 1, wr_ready out 1, wr_time in TIME_W, wr_payload in PAYLOAD_W: command write handshake.
REQ-011 Ports out_valid out 1, out_ready in 1, out_time out TIME_W, out_payload out PAYLOAD_W: command issue handshake.
REQ-012 Port count  out  clog2(DEPTH+1): number of occupied slots.
REQ-013 Port full  out  1: high when count==DEPTH.
REQ-014 Port drop_cnt  out  16: number of stale commands discarded; saturates at 16'hFFFF.

Function
REQ-015 Storage SHALL be DEPTH slots, each holding {valid, time, payload}.
REQ-016 FSM states SHALL be IDLE, SCAN, HOLD and ISSUE.
REQ-017 wr_ready SHALL equal !full && !flush && (state==IDLE || state==HOLD).
REQ-018 An accepted write (wr_valid&&wr_ready) SHALL fill the lowest-index free slot at that clock edge; count SHALL increment at the same edge.
REQ-019 The FSM SHALL enter SCAN on the cycle after an accepted write, after an issue handshake, or after time_reload, unless state==ISSUE.
REQ-020 SCAN SHALL examine exactly one slot per cycle, indexes 0..DEPTH-1.
REQ-021 SCAN SHALL keep the valid slot with the minimum time; on equal times the lower index wins.
REQ-022 On the cycle after the last slot is examined, the FSM SHALL go to HOLD if a candidate was found, else to IDLE.
REQ-023 Latency: a write accepted at edge t into an otherwise empty queue SHALL give SCAN for cycles t+1..t+DEPTH and HOLD at t+DEPTH+1.
REQ-024 In HOLD, if cand_time <= sat(time_now+LEAD), the FSM SHALL go to ISSUE on the next edge.
REQ-025 sat() SHALL clamp the sum to all-ones on TIME_W overflow.
REQ-026 In ISSUE, out_valid SHALL be 1 and out_time/out_payload SHALL be stable until out_ready is sampled high.
REQ-027 ISSUE SHALL NOT be abandoned for time_reload or for a write.
REQ-028 On the issue handshake, the issued slot SHALL be freed, count SHALL decrement, and the FSM SHALL go to SCAN.
REQ-029 A write accepted in HOLD SHALL restart SCAN.
REQ-030 time_reload in SCAN SHALL restart SCAN from index 0.
REQ-031 time_reload in HOLD SHALL go to SCAN.
REQ-032 time_reload in ISSUE SHALL be latched and serviced after the handshake.
REQ-033 flush SHALL have priority over every other event.
REQ-034 On flush: all valid bits clear, count=0, out_valid=0, FSM=IDLE on the next edge; a concurrent write is not accepted.
REQ-035 When full is high and wr_valid is high, the write SHALL stall (wr_ready=0) and no data SHALL be lost.

Reset
REQ-036 rst SHALL asynchronously set: all valid bits 0, count 0, full 0, wr_ready 0, out_valid 0, out_time 0, out_payload 0, drop_cnt 0, FSM IDLE.
REQ-037 Reset asserted mid-SCAN or mid-ISSUE SHALL discard the operation in progress; no handshake completes on that edge.
REQ-038 wr_ready SHALL go high on the first edge after rst deasserts.

Configuration
REQ-039 Macro TCQ_STALE_DROP_EN defined: SCAN SHALL invalidate any valid slot with time < time_now, SHALL exclude it from candidacy, and SHALL increment drop_cnt (saturating).
REQ-040 Macro TCQ_STALE_DROP_EN undefined: stale slots remain candidates and are issued normally; drop_cnt SHALL be tied to 0.

Verification
REQ-041 DEPTH=16, time_now=1000; write times 5000, 3000, 4000 -> out_time sequence 3000, 4000, 5000; each issue only once time_now >= time-384.
REQ-042 Write two commands with time 2000 into slots 2 and 5 -> slot 2 payload issued first.
REQ-043 Fill 16 slots -> full=1, wr_ready=0; write held pending; one issue handshake -> held write accepted, count stays 16.
REQ-044 With macro defined: write time 100, then time_now=500 before scan completes -> no issue, drop_cnt=1, count=0. Without macro: same stimulus -> issued, drop_cnt=0.
REQ-045 out_valid=1 with out_ready=0 for 10 cycles, then time_reload and flush together -> out_valid=0 and count=0 on the next edge.
REQ-046 Assert rst during SCAN -> all outputs at reset values immediately; wr_ready=1 one edge after release.
